// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock player block.
package chess_clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DELAY,
    ST_FLAG
  } state_e;

  localparam string MODE_PLAIN   = "plain";
  localparam string MODE_FISCHER = "fischer";
  localparam string MODE_DELAY   = "delay";

  localparam string FMT_DEC    = "dec";
  localparam string FMT_MINSEC = "minsec";

  // In "minsec" the tens-of-seconds digit (index 1) only spans 0..5.
  function automatic bcd_digit_t digit_max(input int unsigned idx, input bit minsec);
    return (minsec && idx == 1) ? 4'd5 : 4'd9;
  endfunction

endpackage

// File: rtl/chess_bcd_digit.sv
// One BCD digit adder/subtractor with carry/borrow, for an arbitrary base up to 10.
module chess_bcd_digit
  import chess_clock_pkg::*;
#(
  parameter int unsigned p_base = 10
) (
  input  bcd_digit_t i_digit,
  input  bcd_digit_t i_operand,
  input  logic       i_sub,
  input  logic       i_cin,
  output bcd_digit_t o_digit,
  output logic       o_cout
);

  logic [4:0] sum;
  logic [4:0] diff;

  always_comb begin
    sum     = {1'b0, i_digit} + {1'b0, i_operand} + {4'b0, i_cin};
    diff    = {1'b0, i_digit} - {1'b0, i_operand} - {4'b0, i_cin};
    o_digit = '0;
    o_cout  = 1'b0;
    if (i_sub) begin
      if (diff[4]) begin
        o_digit = bcd_digit_t'(diff + 5'(p_base));
        o_cout  = 1'b1;
      end else begin
        o_digit = diff[3:0];
      end
    end else begin
      if (sum >= 5'(p_base)) begin
        o_digit = bcd_digit_t'(sum - 5'(p_base));
        o_cout  = 1'b1;
      end else begin
        o_digit = sum[3:0];
      end
    end
  end

endmodule

// File: rtl/chess_clock_player_px.sv
// One player's side of a chess clock: BCD countdown with plain, Fischer or delay timing.
module chess_clock_player_px
  import chess_clock_pkg::*;
#(
  parameter int unsigned p_divider = 50_000_000,
  parameter int unsigned p_digits  = 4,
  parameter string       p_format  = "minsec",
  parameter string       p_mode    = "fischer",
  parameter int unsigned p_bonus   = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_restart,
  input  logic [p_digits-1:0][3:0]  i_init,
  input  logic                      i_run,
  input  logic                      i_turn_end,
  output logic [p_digits-1:0][3:0]  o_value,
  output logic                      o_zero,
  output logic                      o_running
);

  localparam bit          lp_minsec  = (p_format == FMT_MINSEC);
  localparam bit          lp_fischer = (p_mode == MODE_FISCHER);
  localparam bit          lp_delay   = (p_mode == MODE_DELAY);
  localparam int unsigned lp_pw      = (p_divider > 1) ? $clog2(p_divider) : 1;
  localparam logic [lp_pw-1:0] lp_last  = lp_pw'(p_divider - 1);
  localparam logic [5:0]       lp_bonus = 6'(p_bonus);

  state_e                     state_q, state_d;
  logic [p_digits-1:0][3:0]   value_q, value_d;
  logic [lp_pw-1:0]           presc_q, presc_d;
  logic [5:0]                 dly_q, dly_d;
  logic                       zero_q, zero_d;
  logic                       running_q, running_d;

  logic [p_digits-1:0][3:0]   init_cl;
  logic [p_digits-1:0][3:0]   all_max;
  logic [p_digits-1:0][3:0]   alu_res;
  logic [p_digits:0]          carry;
  logic                       alu_sub;
  logic                       active;
  logic                       tick;

  always_comb begin
    init_cl = '0;
    all_max = '0;
    for (int unsigned i = 0; i < p_digits; i++) begin
      all_max[i] = digit_max(i, lp_minsec);
      init_cl[i] = (i_init[i] > all_max[i]) ? all_max[i] : i_init[i];
    end
  end

  // A single digit chain serves both the per-second decrement and the Fischer add.
  assign alu_sub  = !(lp_fischer && i_turn_end);
  assign carry[0] = alu_sub;

  for (genvar g = 0; g < p_digits; g++) begin : g_digit
    localparam int unsigned lp_base = (lp_minsec && g == 1) ? 6 : 10;
    localparam bcd_digit_t  lp_bon  = (g == 0) ? bcd_digit_t'(p_bonus % 10) :
                                      (g == 1) ? bcd_digit_t'(p_bonus / 10) : '0;
    bcd_digit_t operand;
    assign operand = alu_sub ? '0 : lp_bon;

    chess_bcd_digit #(
      .p_base(lp_base)
    ) u_digit (
      .i_digit   (value_q[g]),
      .i_operand (operand),
      .i_sub     (alu_sub),
      .i_cin     (carry[g]),
      .o_digit   (alu_res[g]),
      .o_cout    (carry[g+1])
    );
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    presc_d = presc_q;
    dly_d   = dly_q;
    active  = (state_q == ST_RUN) || (state_q == ST_DELAY);
    tick    = active && (presc_q == lp_last);

    if (i_restart) begin
      value_d = init_cl;
      presc_d = '0;
      dly_d   = '0;
      state_d = (init_cl == '0) ? ST_FLAG : ST_IDLE;
    end else begin
      if (i_turn_end) begin
        presc_d = '0;
      end else if (active) begin
        presc_d = tick ? '0 : presc_q + lp_pw'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (i_run) begin
            if (lp_delay && p_bonus > 0) begin
              state_d = ST_DELAY;
              dly_d   = lp_bonus;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!i_run) state_d = ST_IDLE;
        end
        ST_DELAY: begin
          if (tick && !i_turn_end) dly_d = dly_q - 6'd1;
          if (!i_run) begin
            state_d = ST_IDLE;
          end else if (tick && !i_turn_end && dly_q <= 6'd1) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_FLAG;
      endcase

      // Turn end outranks a coincident tick; reaching zero overrides any other transition.
      if (lp_fischer && i_turn_end && state_q != ST_FLAG) begin
        value_d = carry[p_digits] ? all_max : alu_res;
      end else if (tick && !i_turn_end && state_q == ST_RUN) begin
        value_d = alu_res;
        if (alu_res == '0) state_d = ST_FLAG;
      end
    end

    zero_d    = (state_d == ST_FLAG);
    running_d = (state_d == ST_RUN) || (state_d == ST_DELAY);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= (init_cl == '0) ? ST_FLAG : ST_IDLE;
      value_q   <= init_cl;
      presc_q   <= '0;
      dly_q     <= '0;
      zero_q    <= (init_cl == '0);
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      presc_q   <= presc_d;
      dly_q     <= dly_d;
      zero_q    <= zero_d;
      running_q <= running_d;
    end
  end

  assign o_value   = value_q;
  assign o_zero    = zero_q;
  assign o_running = running_q;

endmodule
